// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: issues a start pulse to the iterative multiplier or divider,
// counts its fixed latency, then commits HI/LO. Divide-by-zero is caught before
// issue, and flush cancels any in-flight operation.
module muldiv_sequencer #(
   parameter int MULT_CYCLES = 32,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        req_div,
   input  logic [31:0] divisor,
   input  logic        flush,
   output logic        busy,
   output logic        mult_start,
   output logic        div_start,
   output logic        mult_or_div,
   output logic        hi_write,
   output logic        lo_write,
   output logic        done,
   output logic        div_zero
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      RUN   = 3'd2,
      WB    = 3'd3,
      ZERR  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mod_q, mod_d;

   assign mult_or_div = mod_q;

   // State, latency counter and HI/LO select registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mod_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mod_q   <= mod_d;
      end
   end

   // Next-state and Moore output decode; flush overrides everything last.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mod_d      = mod_q;
      busy       = 1'b0;
      mult_start = 1'b0;
      div_start  = 1'b0;
      hi_write   = 1'b0;
      lo_write   = 1'b0;
      done       = 1'b0;
      div_zero   = 1'b0;

      case (state_q)
         IDLE: begin
            if (req) begin
               mod_d = req_div;
               if (req_div && (divisor == '0)) begin
                  state_d = ZERR;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            busy       = 1'b1;
            mult_start = ~mod_q;
            div_start  = mod_q;
            cnt_d      = mod_q ? DIV_LOAD : MULT_LOAD;
            state_d    = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt_q == '0) begin
               state_d = WB;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         WB: begin
            busy     = 1'b1;
            hi_write = 1'b1;
            lo_write = 1'b1;
            done     = 1'b1;
            state_d  = IDLE;
         end
         ZERR: begin
            busy     = 1'b1;
            div_zero = 1'b1;
            done     = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Flush drops any same-cycle request, so the select and counter hold.
      if (flush) begin
         state_d    = IDLE;
         cnt_d      = cnt_q;
         mod_d      = mod_q;
         mult_start = 1'b0;
         div_start  = 1'b0;
         hi_write   = 1'b0;
         lo_write   = 1'b0;
         done       = 1'b0;
         div_zero   = 1'b0;
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with hand-derived cycle-by-cycle outputs.
module tb_muldiv_sequencer;

   localparam int N = 32;

   logic        clock = 1'b0;
   logic        reset;
   logic        req = 1'b0;
   logic        req_div = 1'b0;
   logic [31:0] divisor = 32'd0;
   logic        flush = 1'b0;
   logic        busy, mult_start, div_start, mult_or_div;
   logic        hi_write, lo_write, done, div_zero;

   int tests = 0;
   int fails = 0;

   logic [7:0] obs;
   assign obs = {busy, mult_start, div_start, mult_or_div, hi_write, lo_write, done, div_zero};

   muldiv_sequencer #(
      .MULT_CYCLES(N),
      .DIV_CYCLES (N),
      .CNT_W      (6)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .req        (req),
      .req_div    (req_div),
      .divisor    (divisor),
      .flush      (flush),
      .busy       (busy),
      .mult_start (mult_start),
      .div_start  (div_start),
      .mult_or_div(mult_or_div),
      .hi_write   (hi_write),
      .lo_write   (lo_write),
      .done       (done),
      .div_zero   (div_zero)
   );

   always #5 clock = ~clock;

   // Expected output vector: {busy, mult_start, div_start, mult_or_div, hi_write, lo_write, done, div_zero}
   function automatic logic [7:0] v(input logic b, input logic ms, input logic ds, input logic md,
                                    input logic hw, input logic lw, input logic dn, input logic dz);
      return {b, ms, ds, md, hw, lw, dn, dz};
   endfunction

   task automatic chk(input string tag, input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %b expected %b (busy,ms,ds,mod,hw,lw,done,dz) t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Called in the ISSUE cycle; checks ISSUE, N RUN cycles and WB.
   task automatic op_body(input logic dv, input string tag);
      chk({tag, "_issue"}, v(1, ~dv, dv, dv, 0, 0, 0, 0));
      for (int k = 0; k < N; k++) begin
         tick();
         chk({tag, "_run"}, v(1, 0, 0, dv, 0, 0, 0, 0));
      end
      tick();
      chk({tag, "_wb"}, v(1, 0, 0, dv, 1, 1, 1, 0));
   endtask

   // Full operation from an IDLE cycle back to IDLE.
   task automatic do_op(input logic dv, input logic [31:0] dsr, input string tag);
      req = 1'b1; req_div = dv; divisor = dsr;
      tick();
      req = 1'b0;
      op_body(dv, tag);
      tick();
      chk({tag, "_idle"}, v(0, 0, 0, dv, 0, 0, 0, 0));
   endtask

   initial begin
      // Asynchronous reset, observed before any clock edge.
      reset = 1'b1;
      #3;
      chk("reset", 8'h00);
      @(negedge clock);
      reset = 1'b0;
      tick();
      chk("post_reset_idle", 8'h00);
      tick(); tick(); tick();

      // Multiply, N=32.
      do_op(1'b0, 32'd0, "mult");

      // Divide by 7; select stays 1 after returning to IDLE.
      do_op(1'b1, 32'd7, "div7");
      tick();
      chk("div7_hold", v(0, 0, 0, 1, 0, 0, 0, 0));

      // Divide by zero.
      req = 1'b1; req_div = 1'b1; divisor = 32'd0;
      tick();
      req = 1'b0;
      chk("dz_zerr", v(1, 0, 0, 1, 0, 0, 1, 1));
      tick();
      chk("dz_idle", v(0, 0, 0, 1, 0, 0, 0, 0));
      tick();
      chk("dz_idle2", v(0, 0, 0, 1, 0, 0, 0, 0));

      // Flush in the 10th RUN cycle of a multiply, then an immediate new request.
      req = 1'b1; req_div = 1'b0;
      tick();
      req = 1'b0;
      chk("fl_issue", v(1, 1, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 9; k++) begin
         tick();
         chk("fl_run", v(1, 0, 0, 0, 0, 0, 0, 0));
      end
      tick();
      flush = 1'b1;
      #1;
      chk("fl_cycle", v(1, 0, 0, 0, 0, 0, 0, 0));
      tick();
      flush = 1'b0;
      chk("fl_idle", v(0, 0, 0, 0, 0, 0, 0, 0));
      do_op(1'b1, 32'd5, "after_fl");

      // Flush coincident with WB.
      req = 1'b1; req_div = 1'b0;
      tick();
      req = 1'b0;
      chk("flwb_issue", v(1, 1, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < N; k++) begin
         tick();
         chk("flwb_run", v(1, 0, 0, 0, 0, 0, 0, 0));
      end
      tick();
      flush = 1'b1;
      #1;
      chk("flwb_wb", v(1, 0, 0, 0, 0, 0, 0, 0));
      tick();
      flush = 1'b0;
      chk("flwb_idle", v(0, 0, 0, 0, 0, 0, 0, 0));

      // Flush coincident with an IDLE request: request dropped, select unchanged.
      req = 1'b1; req_div = 1'b1; divisor = 32'd9; flush = 1'b1;
      tick();
      req = 1'b0; flush = 1'b0;
      chk("flreq_idle", v(0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      chk("flreq_idle2", v(0, 0, 0, 0, 0, 0, 0, 0));

      // Asynchronous reset mid-RUN of a divide, away from a clock edge.
      req = 1'b1; req_div = 1'b1; divisor = 32'd3;
      tick();
      req = 1'b0;
      chk("rst_issue", v(1, 0, 1, 1, 0, 0, 0, 0));
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("rst_run", v(1, 0, 0, 1, 0, 0, 0, 0));
      end
      #2;
      reset = 1'b1;
      #1;
      chk("rst_async", 8'h00);
      reset = 1'b0;
      tick();
      chk("rst_idle", 8'h00);
      do_op(1'b0, 32'd0, "post_rst");

      // Request held high across a whole operation.
      req = 1'b1; req_div = 1'b0;
      tick();
      op_body(1'b0, "hold1");
      tick();
      chk("hold_idle", v(0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      req = 1'b0;
      op_body(1'b0, "hold2");
      tick();
      chk("hold2_idle", v(0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      chk("hold2_idle2", v(0, 0, 0, 0, 0, 0, 0, 0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
